// File: rtl/imu_frame_pkg.sv
// Shared constants and FSM encoding for the IMU frame scheduler.
// Byte offsets describe where each sensor group lands inside the 16-byte frame.
package imu_frame_pkg;

    localparam int FRAME_BYTES = 16;
    localparam int ADDR_W      = $clog2(FRAME_BYTES);

    localparam int OFS_TEMP = 0;
    localparam int OFS_GYRO = 2;
    localparam int OFS_MAG  = 8;
    localparam int OFS_SEQ  = 14;
    localparam int OFS_PAD  = 15;

    // Sensor payload occupies every byte below the sequence byte.
    localparam int CAP_W = 8 * OFS_SEQ;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR
    } state_t;

endpackage

// File: rtl/imu_frame_capture.sv
// Coherent capture of one sensor sample, laid out in frame byte order.
// Tracks whether a captured sample still awaits its burst and flags overwrites.
module imu_frame_capture
    import imu_frame_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_valid,
    input  logic [15:0]      temp_data,
    input  logic [15:0]      gyro_x,
    input  logic [15:0]      gyro_y,
    input  logic [15:0]      gyro_z,
    input  logic [15:0]      mag_x,
    input  logic [15:0]      mag_y,
    input  logic [15:0]      mag_z,
    input  logic             take,
    output logic [CAP_W-1:0] cap_p0,
    output logic             pending,
    output logic             overrun
);

    // Stage 0: capture register, loaded straight into little-endian frame layout
    always_ff @(posedge clk) begin
        if (sample_valid) begin
            cap_p0[8*OFS_TEMP       +: 16] <= temp_data;
            cap_p0[8*OFS_GYRO       +: 16] <= gyro_x;
            cap_p0[8*(OFS_GYRO + 2) +: 16] <= gyro_y;
            cap_p0[8*(OFS_GYRO + 4) +: 16] <= gyro_z;
            cap_p0[8*OFS_MAG        +: 16] <= mag_x;
            cap_p0[8*(OFS_MAG + 2)  +: 16] <= mag_y;
            cap_p0[8*(OFS_MAG + 4)  +: 16] <= mag_z;
        end
    end

    // A sample arriving on the burst-start edge replaces one that is being consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= sample_valid && pending && !take;
            if (sample_valid) begin
                pending <= 1'b1;
            end else if (take) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/imu_frame_sched.sv
// Frame RAM owner: arbitrates host byte reads against atomic 16-byte frame bursts.
// Reads win in IDLE; a started burst always runs to completion.
module imu_frame_sched
    import imu_frame_pkg::*;
#(
    parameter int SEQ_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [15:0]       temp_data,
    input  logic [15:0]       gyro_x,
    input  logic [15:0]       gyro_y,
    input  logic [15:0]       gyro_z,
    input  logic [15:0]       mag_x,
    input  logic [15:0]       mag_y,
    input  logic [15:0]       mag_z,
    input  logic              frame_lock,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata,
    output logic              busy,
    output logic [SEQ_W-1:0]  frame_seq,
    output logic              overrun
);

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   idx_p1, idx_nx;
    logic [CAP_W-1:0]    cap_p0, burst_p1;
    logic                pending, take;
    logic                seq_inc, seq_inc_nx;
    logic [SEQ_W-1:0]    seq_next;
    logic [7:0]          wr_byte;
    logic [ADDR_W-1:0]   ram_addr_nx;
    logic [7:0]          ram_wdata_nx, rd_data_nx;
    logic                ram_we_nx, rd_valid_nx;

    imu_frame_capture u_capture (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .temp_data    (temp_data),
        .gyro_x       (gyro_x),
        .gyro_y       (gyro_y),
        .gyro_z       (gyro_z),
        .mag_x        (mag_x),
        .mag_y        (mag_y),
        .mag_z        (mag_z),
        .take         (take),
        .cap_p0       (cap_p0),
        .pending      (pending),
        .overrun      (overrun)
    );

    assign busy     = (state != ST_IDLE);
    assign seq_next = frame_seq + SEQ_W'(1);

    // Byte 14 carries the value frame_seq will hold once this frame commits.
    always_comb begin
        wr_byte = 8'h00;
        if (idx_p1 < ADDR_W'(OFS_SEQ)) begin
            wr_byte = burst_p1[8*idx_p1 +: 8];
        end else if (idx_p1 == ADDR_W'(OFS_SEQ)) begin
            wr_byte = 8'(seq_next);
        end
    end

    always_comb begin
        state_nx     = state;
        idx_nx       = idx_p1;
        take         = 1'b0;
        seq_inc_nx   = 1'b0;
        ram_addr_nx  = ram_addr;
        ram_wdata_nx = ram_wdata;
        ram_we_nx    = 1'b0;
        rd_data_nx   = rd_data;
        rd_valid_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rd_req) begin
                    state_nx    = ST_RD_ADDR;
                    ram_addr_nx = rd_addr;
                end else if (pending && !frame_lock) begin
                    state_nx = ST_WR;
                    take     = 1'b1;
                    idx_nx   = '0;
                end
            end
            ST_RD_ADDR: state_nx = ST_RD_DATA;
            ST_RD_DATA: begin
                state_nx    = ST_IDLE;
                rd_data_nx  = ram_rdata;
                rd_valid_nx = 1'b1;
            end
            ST_WR: begin
                ram_we_nx    = 1'b1;
                ram_addr_nx  = idx_p1;
                ram_wdata_nx = wr_byte;
                idx_nx       = idx_p1 + ADDR_W'(1);
                if (idx_p1 == ADDR_W'(OFS_PAD)) begin
                    state_nx   = ST_IDLE;
                    seq_inc_nx = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Stage 1: burst register snapshots the capture when a burst starts
    always_ff @(posedge clk) begin
        if (take) begin
            burst_p1 <= cap_p0;
        end
    end

    // The commit is delayed one edge so frame_seq moves together with ram_we falling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx_p1    <= '0;
            seq_inc   <= 1'b0;
            frame_seq <= '0;
            ram_addr  <= '0;
            ram_wdata <= 8'h00;
            ram_we    <= 1'b0;
            rd_data   <= 8'h00;
            rd_valid  <= 1'b0;
        end else begin
            state     <= state_nx;
            idx_p1    <= idx_nx;
            seq_inc   <= seq_inc_nx;
            ram_addr  <= ram_addr_nx;
            ram_wdata <= ram_wdata_nx;
            ram_we    <= ram_we_nx;
            rd_data   <= rd_data_nx;
            rd_valid  <= rd_valid_nx;
            if (seq_inc) begin
                frame_seq <= seq_next;
            end
        end
    end

endmodule

// File: tb/tb_imu_frame_sched.sv
// Bench for imu_frame_sched: table vectors, hand-written corner sequences and
// randomized frames checked against a frame-level model of the byte map.
module tb_imu_frame_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_valid;
    logic [15:0] temp_data, gyro_x, gyro_y, gyro_z, mag_x, mag_y, mag_z;
    logic        frame_lock;
    logic        rd_req;
    logic [3:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [3:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;
    logic        busy;
    logic [7:0]  frame_seq;
    logic        overrun;

    always #5 clk = ~clk;

    imu_frame_sched #(.SEQ_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .temp_data    (temp_data),
        .gyro_x       (gyro_x),
        .gyro_y       (gyro_y),
        .gyro_z       (gyro_z),
        .mag_x        (mag_x),
        .mag_y        (mag_y),
        .mag_z        (mag_z),
        .frame_lock   (frame_lock),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_we       (ram_we),
        .ram_rdata    (ram_rdata),
        .busy         (busy),
        .frame_seq    (frame_seq),
        .overrun      (overrun)
    );

    // Single-port synchronous RAM, read-first, one-cycle read latency
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        int           cnt;
        bit           ok;
        logic [127:0] data;
    } rec_t;

    typedef struct {
        logic [111:0] w;
        logic [3:0]   addr;
        logic [7:0]   exp;
    } vec_t;

    rec_t         got_q[$];
    logic [127:0] exp_q[$];
    rec_t         last_rec;
    logic [127:0] last_exp;
    logic [7:0]   exp_seq;
    int           checks = 0;
    int           errors = 0;

    int           m_cnt  = 0;
    bit           m_ok   = 1'b1;
    bit           m_act  = 1'b0;
    logic [127:0] m_data = '0;
    int           ovr_cnt = 0;

    // Collect each run of ram_we into one burst record
    always @(negedge clk) begin
        if (overrun) ovr_cnt <= ovr_cnt + 1;
        if (ram_we) begin
            if (m_cnt < 16) m_data[8*m_cnt +: 8] <= ram_wdata;
            if (32'(ram_addr) != m_cnt) m_ok <= 1'b0;
            m_cnt <= m_cnt + 1;
            m_act <= 1'b1;
        end else if (m_act) begin
            got_q.push_back('{cnt: m_cnt, ok: (m_ok && m_cnt == 16), data: m_data});
            m_cnt <= 0;
            m_ok  <= 1'b1;
            m_act <= 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Frame model: little-endian words, then post-increment sequence, then pad
    task automatic push_exp(input logic [111:0] w);
        exp_seq  = exp_seq + 8'd1;
        last_exp = {8'h00, exp_seq, w};
        exp_q.push_back(last_exp);
    endtask

    task automatic send(input logic [111:0] w);
        {mag_z, mag_y, mag_x, gyro_z, gyro_y, gyro_x, temp_data} = w;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int   t;
        rec_t r;
        while (exp_q.size() > 0) begin
            t = 0;
            while (got_q.size() == 0 && t < 300) begin
                tick();
                t++;
            end
            if (got_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s burst timeout, %0d frames still expected", name, exp_q.size());
                exp_q.delete();
            end else begin
                r = got_q.pop_front();
                last_rec = r;
                chk({name, " burst shape"}, 128'({r.ok, 32'(r.cnt)}), 128'({1'b1, 32'd16}));
                chk({name, " frame"}, r.data, exp_q.pop_front());
            end
        end
    endtask

    task automatic do_read(input logic [3:0] a, output int n, output logic [7:0] d,
                           output logic single);
        rd_addr = a;
        rd_req  = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rd_valid && n < 100);
        d      = rd_data;
        rd_req = 1'b0;
        tick();
        single = !rd_valid;
    endtask

    task automatic check_reset(input string name);
        chk({name, " read side"}, 128'({rd_data, rd_valid}), 128'(0));
        chk({name, " ram side"}, 128'({ram_addr, ram_wdata, ram_we}), 128'(0));
        chk({name, " status"}, 128'({busy, frame_seq, overrun}), 128'(0));
    endtask

    task automatic wait_we(input string name);
        int t = 0;
        while (!ram_we && t < 50) begin
            tick();
            t++;
        end
        chk({name, " burst started"}, 128'(ram_we), 128'(1));
    endtask

    vec_t         tbl[6];
    logic [111:0] wa, wb;
    int           n, o0;
    logic [7:0]   d;
    logic         single;
    logic [3:0]   a;
    rec_t         r;

    initial begin
        // Table: words {mz,my,mx,gz,gy,gx,temp}, read address, hand-derived byte
        tbl[0] = '{w: {16'h0D0E, 16'h0B0C, 16'h090A, 16'h0708, 16'h0506, 16'h0304, 16'h0102},
                   addr: 4'd9,  exp: 8'h09};
        tbl[1] = '{w: {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5AA5, 16'h6666, 16'hFFEE},
                   addr: 4'd5,  exp: 8'h5A};
        tbl[2] = '{w: {16'h7777, 16'h8888, 16'h9999, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD},
                   addr: 4'd14, exp: 8'h08};
        tbl[3] = '{w: {16'hC3D4, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
                   addr: 4'd12, exp: 8'hD4};
        tbl[4] = '{w: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                   addr: 4'd15, exp: 8'h00};
        tbl[5] = '{w: {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8001},
                   addr: 4'd1,  exp: 8'h80};

        rst_n = 1'b0;
        sample_valid = 1'b0;
        {mag_z, mag_y, mag_x, gyro_z, gyro_y, gyro_x, temp_data} = '0;
        frame_lock = 1'b0;
        rd_req = 1'b0;
        rd_addr = 4'd0;
        exp_seq = 8'd0;
        repeat (3) tick();
        check_reset("reset");
        @(negedge clk) rst_n = 1'b1;
        tick();

        // First frame and a host read of byte 3
        wa = {80'h0, 16'hABCD, 16'h1234};
        push_exp(wa);
        send(wa);
        drain("first");
        chk("first byte14", 128'(last_rec.data[119:112]), 128'(8'h01));
        chk("first frame_seq", 128'(frame_seq), 128'(1));
        do_read(4'd3, n, d, single);
        chk("first read latency", 128'(n), 128'(3));
        chk("first read data", 128'(d), 128'(8'hAB));
        chk("first read single pulse", 128'(single), 128'(1));

        // Read requested at burst cycle 5 waits for the burst to finish
        wa = 112'({$urandom(), $urandom(), $urandom(), $urandom()});
        push_exp(wa);
        send(wa);
        wait_we("held read");
        repeat (4) tick();
        do_read(4'd0, n, d, single);
        chk("held read latency", 128'(n), 128'(14));
        chk("held read data", 128'(d), 128'(wa[7:0]));
        drain("held read");

        // Locked: no bursts, second sample overruns, release writes the second sample
        frame_lock = 1'b1;
        wa = 112'({$urandom(), $urandom(), $urandom(), $urandom()});
        wb = 112'({$urandom(), $urandom(), $urandom(), $urandom()});
        send(wa);
        repeat (20) tick();
        chk("lock no writes", 128'({got_q.size(), m_act}), 128'(0));
        chk("lock idle", 128'(busy), 128'(0));
        send(wb);
        chk("lock overrun", 128'(overrun), 128'(1));
        tick();
        chk("lock overrun pulse", 128'(overrun), 128'(0));
        push_exp(wb);
        frame_lock = 1'b0;
        drain("lock release");

        // Sample on the burst-start edge: old value bursts, new one stays pending
        o0 = ovr_cnt;
        wa = 112'({$urandom(), $urandom(), $urandom(), $urandom()});
        wb = 112'({$urandom(), $urandom(), $urandom(), $urandom()});
        push_exp(wa);
        push_exp(wb);
        send(wa);
        send(wb);
        drain("same edge");
        chk("same edge no overrun", 128'(ovr_cnt - o0), 128'(0));

        for (int i = 0; i < 6; i++) begin
            push_exp(tbl[i].w);
            send(tbl[i].w);
            drain("table");
            do_read(tbl[i].addr, n, d, single);
            chk("table read latency", 128'(n), 128'(3));
            chk("table read data", 128'(d), 128'(tbl[i].exp));
        end

        // Randomized frames with occasional reads checked against the model
        o0 = ovr_cnt;
        for (int i = 0; i < 30; i++) begin
            wa = 112'({$urandom(), $urandom(), $urandom(), $urandom()});
            push_exp(wa);
            send(wa);
            drain("random");
            chk("random frame_seq", 128'(frame_seq), 128'(exp_seq));
            if ($urandom_range(0, 1) == 1) begin
                a = 4'($urandom_range(0, 15));
                do_read(a, n, d, single);
                chk("random read data", 128'(d), 128'(last_exp[8*a +: 8]));
            end
            repeat ($urandom_range(0, 5)) tick();
        end
        chk("random no overrun", 128'(ovr_cnt - o0), 128'(0));

        // Reset at burst cycle 8 aborts the frame without committing it
        wa = 112'({$urandom(), $urandom(), $urandom(), $urandom()});
        send(wa);
        wait_we("abort");
        repeat (7) tick();
        #2 rst_n = 1'b0;
        #1 check_reset("abort");
        @(negedge clk) rst_n = 1'b1;
        repeat (20) tick();
        chk("abort stays idle", 128'({busy, ram_we}), 128'(0));
        chk("abort partial count", 128'(got_q.size()), 128'(1));
        if (got_q.size() > 0) begin
            r = got_q.pop_front();
            chk("abort partial short", 128'(r.cnt < 16), 128'(1));
        end
        got_q.delete();
        exp_seq = 8'd0;

        // 256 frames at the 17-cycle minimum period: sequence wraps to zero
        o0 = ovr_cnt;
        for (int i = 0; i < 256; i++) begin
            wa = 112'({$urandom(), $urandom(), $urandom(), $urandom()});
            push_exp(wa);
            send(wa);
            repeat (16) tick();
        end
        drain("wrap");
        chk("wrap frame_seq", 128'(frame_seq), 128'(0));
        chk("wrap byte14", 128'(last_rec.data[119:112]), 128'(8'h00));
        chk("wrap no overrun", 128'(ovr_cnt - o0), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imu_frame_sched.md
# imu_frame_sched

Scheduler for the 16-byte IMU frame RAM. It captures sensor samples coherently and owns the single-port synchronous frame RAM. The RAM is shared between two users: a burst writer that commits each sample as one 16-byte frame, and a host byte-read port. The block sits between the sensor readers (temperature, gyro, magnetometer) and the host interface logic (UART/SPI readout).

## Interface
- FRAME_BYTES, 16: frame length in bytes; the RAM address is 4 bits.
- SEQ_W, 8: width of the frame sequence counter.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- sample_valid  in  1  one-cycle strobe; all sensor words below are valid.
- temp_data, gyro_x, gyro_y, gyro_z, mag_x, mag_y, mag_z  in  16 each  sensor words.
- frame_lock  in  1  host is reading a frame; no new burst may start while high.
- rd_req  in  1  host byte read request (level); rd_addr must stay stable until rd_valid.
- rd_addr  in  4  host read address.
- rd_data  out  8  read byte; valid while rd_valid is high.
- rd_valid  out  1  one-cycle pulse.
- ram_addr  out  4  RAM address (registered).
- ram_wdata  out  8  RAM write data (registered).
- ram_we  out  1  RAM write enable (registered).
- ram_rdata  in  8  RAM read data; valid one cycle after the address is presented.
- busy  out  1  FSM is not in IDLE.
- frame_seq  out  SEQ_W  count of committed frames; wraps.
- overrun  out  1  one-cycle pulse when a pending, uncommitted sample is overwritten.

## Operation
- Capture register (112 bits) loads all seven words on sample_valid and sets pending.
- If pending is already set on sample_valid: capture is overwritten and overrun pulses on the next cycle.
- Frame byte map, little-endian words:
  - 0–1: temp
  - 2–7: gyro x, y, z
  - 8–13: mag x, y, z
  - 14: new frame_seq value
  - 15: 0x00
- FSM states:
  - IDLE
  - RD_ADDR
  - RD_DATA
  - WR
- IDLE priority order:
  - 1. rd_req=1: go to RD_ADDR; ram_addr<=rd_addr, ram_we<=0.
  - 2. pending && !frame_lock: go to WR. The capture register is copied to the burst register, pending clears, and the byte index resets to 0.
  - 3. Otherwise stay in IDLE.
- RD_ADDR → RD_DATA. RD_DATA → IDLE, with rd_data<=ram_rdata and rd_valid<=1.
- WR: each cycle, ram_we<=1, ram_addr<=idx, ram_wdata<=byte(idx), idx++.
  - After idx 15 is issued: go to IDLE, ram_we<=0, frame_seq<=frame_seq+1.
- A WR burst is atomic:
  - rd_req is held off until the burst ends.
  - frame_lock asserted mid-burst does not abort it.
- Reads can starve writes indefinitely; sample overrun is reported, never blocked.
- Simultaneous sample_valid and burst start on the same edge:
  - The burst takes the old capture value.
  - The capture register takes the new value.
  - pending stays 1; no overrun.
- Reset mid-burst aborts immediately. RAM may hold a partial frame; frame_seq is not advanced.

## Timing
- Reset values:
  - rd_data=0, rd_valid=0
  - ram_addr=0, ram_wdata=0, ram_we=0
  - busy=0, frame_seq=0, overrun=0
  - state IDLE, pending=0
- Read latency: accepted at edge E0 in IDLE; rd_valid is high from E2 to E3.
- rd_req is sampled only in IDLE. If rd_req is still high at E3, a new read is accepted.
- Write burst: ram_we is high for exactly 16 consecutive cycles, addresses 0..15 in order.
- frame_seq updates at the same edge that drops ram_we.
- Minimum frame period sustained without overrun: 17 cycles with no reads.
- frame_seq wraps from 255 to 0. Byte 14 carries the post-increment value, so the frame after seq 255 carries 0x00.

## Structure
- Package imu_frame_pkg contains:
  - FRAME_BYTES
  - byte-offset constants (OFS_TEMP=0, OFS_GYRO=2, OFS_MAG=8, OFS_SEQ=14, OFS_PAD=15)
  - the FSM state enum
- Sub-module imu_frame_capture holds the capture register, the pending flag and the overrun pulse. The top level keeps the FSM, the burst register and the byte mux.

## Test plan
- Reset, then sample_valid with temp=0x1234 and gyro_x=0xABCD:
  - 16 writes follow.
  - Byte 0=0x34, byte 1=0x12, byte 2=0xCD, byte 3=0xAB, byte 14=0x01, byte 15=0x00.
  - frame_seq=1.
- Host read of addr 3 after that frame: rd_valid is a single pulse 2 edges after acceptance, with rd_data=0xAB.
- rd_req asserted at burst cycle 5: no rd_valid until the burst ends; rd_valid follows 2 edges after the return to IDLE.
- frame_lock=1 with sample_valid: no ram_we while locked. A second sample_valid pulses overrun. On release, the frame carries the second sample's values.
- 256 sample/burst cycles: frame_seq wraps to 0 and byte 14 of the last frame is 0x00.
- rst_n low at burst cycle 8:
  - All outputs return to reset values immediately; frame_seq=0.
  - After release the FSM idles until the next sample_valid.
